perip_uart_tx: RTL
==================

Name: perip_uart_tx

Overview:
Memory-mapped UART transmitter sitting on the Processor's 8-bit peripheral bus. It is the responder end of the bus that the Processor drives as initiator. CPU writes push bytes into a small TX FIFO, and the block serialises them as 8N1, LSB first, on o_tx. CPU reads return a status byte. Read data is zero when the block is not addressed, so several peripherals can be OR-combined onto i_peripDataToCPU.

Parameters:
BASE_ADDR, 8'hF0, bus address of the TXDATA register; STATUS is at BASE_ADDR+1.
CLKS_PER_BIT, 104, i_clk cycles per UART bit (12 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 4, TX FIFO entries; power of 2, range 2..16.

Ports:
i_clk  in  1  system clock (12 MHz)
i_rst  in  1  synchronous active-high reset
i_peripAddr  in  8  bus address from the CPU (the CPU's o_peripAddr)
i_peripDataFromCPU  in  8  write data from the CPU
i_peripWrSig  in  1  write strobe, one cycle per access
i_peripRdSig  in  1  read strobe, one cycle per access
o_peripDataToCPU  out  8  registered read data to the CPU
o_tx  out  1  UART serial output, idle high
o_busy  out  1  high while the FIFO is non-empty or a frame is in flight

Behaviour:
- Reset (i_rst high at a clock edge) has priority over everything, including mid-frame:
  - o_tx=1, o_busy=0, o_peripDataToCPU=0.
  - FIFO emptied (pointers=0, count=0), overflow flag=0, FSM=IDLE.
  - Baud and bit counters cleared.
  - A frame in progress is truncated; the line returns high immediately.
- Address decode: sel_data = (i_peripAddr==BASE_ADDR); sel_stat = (i_peripAddr==BASE_ADDR+1); 8-bit compare, wrap-around allowed (BASE_ADDR=8'hFF puts STATUS at 8'h00).
- Write, i_peripWrSig & sel_data:
  - If FIFO is not full at the start of the cycle, the byte is pushed.
  - Otherwise the byte is dropped and the overflow flag is set.
  - A pop in the same cycle does not rescue a write made while full.
- Write, i_peripWrSig & sel_stat: ignored (no side effects).
- Read latency is 1 cycle. o_peripDataToCPU is registered at the edge where i_peripRdSig is sampled high and is valid in the following cycle.
  - Read with sel_stat returns {4'b0, overflow, fifo_empty, fifo_full, busy} (bits 3..0).
  - Read with sel_data returns 8'h00.
  - No read, or an unselected read: o_peripDataToCPU=0 on the next cycle.
- Overflow is sticky. It is cleared by a STATUS read; if an overflow occurs in the same cycle as that read, set wins (flag stays 1). The returned value is the pre-clear value.
- i_peripRdSig and i_peripWrSig high in the same cycle: both are processed independently.
- TX FSM, baud counter counts 0..CLKS_PER_BIT-1:
  - IDLE: o_tx=1. If FIFO non-empty, pop the head into the shift register and go to START next cycle. Pop happens in the IDLE cycle.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: o_tx=shift[0]. After CLKS_PER_BIT cycles, shift right; after 8 bits go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - One frame = 1 IDLE cycle + 10*CLKS_PER_BIT cycles. Back-to-back bytes therefore have exactly one extra idle-high cycle between frames.
- o_tx and o_busy are registered outputs. Write-to-start-bit latency from an idle, empty state:
  - write at edge N → pop at N+1 → o_tx=0 from edge N+2.
- o_busy = (FSM!=IDLE) | !fifo_empty. Deassertion is registered, after the last STOP bit completes.
- FIFO count range is 0..FIFO_DEPTH. Full means count==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Single byte, CLKS_PER_BIT=4: reset 4 cycles, write 8'hA5 to BASE_ADDR → o_tx low starting 2 cycles later, then bits 1,0,1,0,0,1,0,1 (LSB first), each 4 cycles, stop high 4 cycles; o_busy drops after stop.
2. Status read: while case 1 runs, read BASE_ADDR+1 → next cycle o_peripDataToCPU=8'h05 (busy=1, empty=1); idle read → 8'h04.
3. Overflow: DEPTH=4, CLKS_PER_BIT=4. Write 6 bytes 8'h01..8'h06 on consecutive cycles.
   - The first byte is popped at cycle 2, so 8'h06 is dropped.
   - STATUS reads 8'h0B (overflow, full, busy).
   - A second STATUS read returns overflow=0.
   - The serial stream is 01,02,03,04,05.
4. Back-to-back: write 8'h00 then 8'hFF → exactly one idle-high cycle between stop of frame 1 and start of frame 2; total span 2*(1+40) cycles.
5. Reset mid-frame: assert i_rst during DATA bit 3 → next cycle o_tx=1, o_busy=0, STATUS=8'h04; a new write transmits correctly from a clean start.
6. Decode isolation: write/read BASE_ADDR+2 and 8'h00 → no FIFO push, no TX, o_peripDataToCPU stays 8'h00.

Source files
------------

// File: rtl/perip_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the 8-bit peripheral bus.
// TXDATA at BASE_ADDR (write pushes into the TX FIFO), STATUS at BASE_ADDR+1 (read-only).
// Read data is zero unless STATUS is read, so several peripherals can be OR-combined.
module perip_uart_tx #(
  parameter logic [7:0]  BASE_ADDR    = 8'hF0,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_peripAddr,
  input  logic [7:0] i_peripDataFromCPU,
  input  logic       i_peripWrSig,
  input  logic       i_peripRdSig,
  output logic [7:0] o_peripDataToCPU,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned    PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned    CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);
  localparam logic [15:0]    BaudLast = 16'(CLKS_PER_BIT - 1);
  // 8-bit add wraps, so BASE_ADDR=8'hFF puts STATUS at 8'h00
  localparam logic [7:0]     StatAddr = BASE_ADDR + 8'd1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [7:0]      rdata_q, rdata_d;

  logic sel_data, sel_stat;
  logic fifo_full, fifo_empty;
  logic wr_data, push, pop, busy_now;
  logic [7:0] status;

  // Bus decode, FIFO flags and push/pop qualification
  always_comb begin
    sel_data   = (i_peripAddr == BASE_ADDR);
    sel_stat   = (i_peripAddr == StatAddr);
    fifo_full  = (count_q == DepthC);
    fifo_empty = (count_q == '0);
    wr_data    = i_peripWrSig & sel_data;
    // Fullness is judged at the start of the cycle; a same-cycle pop does not make room
    push       = wr_data & ~fifo_full;
    pop        = (state_q == StIdle) & ~fifo_empty;
    busy_now   = (state_q != StIdle) | ~fifo_empty;
    status     = {4'b0000, ovf_q, fifo_empty, fifo_full, busy_now};
  end

  // FIFO pointer, occupancy, sticky overflow and read-data next state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    // A new overflow wins over the clear from a STATUS read
    ovf_d   = (ovf_q & ~(i_peripRdSig & sel_stat)) | (wr_data & fifo_full);
    rdata_d = (i_peripRdSig && sel_stat) ? status : 8'h00;
  end

  // Transmit FSM: IDLE pops, then START, 8 DATA bits LSB first, STOP
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level and busy are registered from the current state, one cycle behind the FSM
  always_comb begin
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = busy_now;
  end

  // State registers with synchronous reset; reset truncates any frame in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem_q[wr_ptr_q] <= i_peripDataFromCPU;
    end
  end

  assign o_peripDataToCPU = rdata_q;
  assign o_tx             = tx_q;
  assign o_busy           = busy_q;

endmodule
